// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the writeback write-port arbiter.
// wb_entry_t is the buffered port B result; its field widths set the
// register index and data widths used throughout the arbiter.
package wb_write_arbiter_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_ADDR_WIDTH = 5;

  // Architectural zero register; writes to it are discarded.
  localparam logic [WB_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  // Source driving the registered write port in a given cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } wb_sel_e;

  // True when an enabled compare hits the given register index.
  function automatic logic addr_hit(input logic en,
                                    input logic [WB_ADDR_WIDTH-1:0] a,
                                    input logic [WB_ADDR_WIDTH-1:0] b);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// wb_fifo: circular buffer of wb_entry_t for port B results.
// Each entry carries its own valid bit, so a younger port A write can squash
// a buffered entry in place without disturbing FIFO order. A squashed entry
// still occupies its slot until popped. Valid bits are cleared on pop, which
// means a set valid bit always denotes an occupied, live entry.
// Optional: WB_PENDING_MASK_EN adds pending_mask, one bit per register index.
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     squash_en,
  input  logic [WB_ADDR_WIDTH-1:0] squash_addr,
  output wb_entry_t                head,
`ifdef WB_PENDING_MASK_EN
  output logic [2**WB_ADDR_WIDTH-1:0] pending_mask,
`endif
  output logic [CNT_W-1:0]         count
);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Flattened views of the per-entry storage for head selection and masks.
  logic [DEPTH-1:0]                    vld_vec;
  logic [DEPTH-1:0][WB_ADDR_WIDTH-1:0] addr_vec;
  logic [DEPTH-1:0][WB_DATA_WIDTH-1:0] data_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                     vld_reg;
      logic                     vld_next;
      logic [WB_ADDR_WIDTH-1:0] addr_reg;
      logic [WB_DATA_WIDTH-1:0] data_reg;
      logic                     wr_sel;
      logic                     rd_sel;

      assign wr_sel = push && (wr_ptr_reg == PTR_W'(gi));
      assign rd_sel = pop && (rd_ptr_reg == PTR_W'(gi));

      // Entry valid update: a fresh push wins, then pop, then squash.
      // A write slot is never also the popped or squashed live slot,
      // because pushes only occur while the FIFO is not full.
      always_comb begin
        vld_next = vld_reg;
        if (wr_sel) begin
          vld_next = push_entry.valid;
        end else if (rd_sel) begin
          vld_next = 1'b0;
        end else if (addr_hit(squash_en, addr_reg, squash_addr)) begin
          vld_next = 1'b0;
        end
      end

      // Valid bit register, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_reg <= 1'b0;
        end else begin
          vld_reg <= vld_next;
        end
      end

      // Address/data payload; only meaningful while the valid bit is set.
      always_ff @(posedge clk) begin
        if (wr_sel) begin
          addr_reg <= push_entry.addr;
          data_reg <= push_entry.data;
        end
      end

      assign vld_vec[gi]  = vld_reg;
      assign addr_vec[gi] = addr_reg;
      assign data_vec[gi] = data_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Present the oldest entry, including its squash status.
  always_comb begin
    head.valid = vld_vec[rd_ptr_reg];
    head.addr  = addr_vec[rd_ptr_reg];
    head.data  = data_vec[rd_ptr_reg];
  end

`ifdef WB_PENDING_MASK_EN
  // One bit per register that a live buffered entry will still write.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_vec[i]) begin
        pending_mask[addr_vec[i]] = 1'b1;
      end
    end
  end
`endif

  assign count = count_reg;

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the single-cycle ALU result (port A) and the
// variable-latency memory/mul-div result (port B) into one registered
// register-file write per cycle. Port A always wins; port B results wait in
// wb_fifo and drain when port A is idle. A port A write squashes older
// buffered port B writes to the same register so the last writer is A.
// Optional: WB_PENDING_MASK_EN exposes PENDING_MASK for the hazard unit.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  A_VALID,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DATA,
  input  logic                  B_VALID,
  output logic                  B_READY,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_DATA,
  output logic                  REG_WRITE_EN,
  output logic [ADDR_WIDTH-1:0] REG_WRITE_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WRITE_DATA,
`ifdef WB_PENDING_MASK_EN
  output logic [2**ADDR_WIDTH-1:0] PENDING_MASK,
`endif
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             a_write;
  logic             b_fire;
  logic             b_push;
  logic             b_pop;
  wb_entry_t        push_entry;
  wb_entry_t        head;
  logic [CNT_W-1:0] fifo_count;
  wb_sel_e          sel;

  logic                  wr_en_reg;
  logic                  wr_en_next;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_next;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [DATA_WIDTH-1:0] wr_data_next;

  // Writes to x0 are architectural no-ops on either port.
  assign a_write = A_VALID && (A_ADDR != REG_ZERO);
  assign b_fire  = B_VALID && B_READY;
  assign b_push  = b_fire && (B_ADDR != REG_ZERO);

  // Ready depends only on registered occupancy: a full FIFO refuses even
  // when it pops in the same cycle.
  assign B_READY = (fifo_count < CNT_W'(DEPTH));
  assign BUSY    = (fifo_count != '0);

  // Same-cycle B is older than A, so a B entry hitting A's target is
  // enqueued pre-squashed.
  always_comb begin
    push_entry.valid = !addr_hit(a_write, B_ADDR, A_ADDR);
    push_entry.addr  = B_ADDR;
    push_entry.data  = B_DATA;
  end

  // Write-port source: A first, otherwise drain the FIFO head.
  always_comb begin
    sel = SEL_NONE;
    if (a_write) begin
      sel = SEL_A;
    end else if (fifo_count != '0) begin
      sel = SEL_B;
    end
  end

  assign b_pop = (sel == SEL_B);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (CLK),
    .rst_n        (RESET),
    .push         (b_push),
    .push_entry   (push_entry),
    .pop          (b_pop),
    .squash_en    (a_write),
    .squash_addr  (A_ADDR),
    .head         (head),
`ifdef WB_PENDING_MASK_EN
    .pending_mask (PENDING_MASK),
`endif
    .count        (fifo_count)
  );

  // Next write-port contents; a squashed head pops with the strobe low.
  always_comb begin
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    case (sel)
      SEL_A: begin
        wr_en_next   = 1'b1;
        wr_addr_next = A_ADDR;
        wr_data_next = A_DATA;
      end
      SEL_B: begin
        wr_en_next   = head.valid;
        wr_addr_next = head.addr;
        wr_data_next = head.data;
      end
      default: begin
        wr_en_next = 1'b0;
      end
    endcase
  end

  // Registered write port toward reg_file.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  assign REG_WRITE_EN   = wr_en_reg;
  assign REG_WRITE_ADDR = wr_addr_reg;
  assign REG_WRITE_DATA = wr_data_reg;

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side producer for the register file write port: merges results from the single-cycle ALU path (port A) and the variable-latency memory/mul-div path (port B) into one registered write per cycle.
- Port A always wins the write port. Port B results wait in a small FIFO and drain when port A is idle.
- Enforces WAW ordering by squashing buffered B entries that a younger A write overtakes.
- Sits between the execute/memory stages and reg_file; its outputs drive DATA_IN, INADDRESS and WRITE_EN.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width (32 registers)
- DEPTH, 4, port B FIFO entries; power of two, at least 2

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  reset, asynchronous assert, active-low
- A_VALID  in  1  ALU result valid; no ready signal, always accepted
- A_ADDR  in  ADDR_WIDTH  ALU destination register
- A_DATA  in  DATA_WIDTH  ALU result
- B_VALID  in  1  memory-path result valid
- B_READY  out  1  FIFO can accept; transfer occurs when B_VALID && B_READY
- B_ADDR  in  ADDR_WIDTH  memory-path destination register
- B_DATA  in  DATA_WIDTH  memory-path result
- REG_WRITE_EN  out  1  write strobe to reg_file
- REG_WRITE_ADDR  out  ADDR_WIDTH  write address to reg_file
- REG_WRITE_DATA  out  DATA_WIDTH  write data to reg_file
- BUSY  out  1  FIFO holds at least one entry (valid or squashed)

Behaviour:
- Reset, RESET=0 (async):
  - FIFO pointers, count and entry valid bits cleared.
  - REG_WRITE_EN=0, REG_WRITE_ADDR=0, REG_WRITE_DATA=0, BUSY=0.
  - B_READY=1 once reset is released.
  - A transfer in flight during reset is lost.
- Write outputs are registered. An accepted A appears on REG_WRITE_* on the cycle after acceptance. A B entry appears on the cycle after it is popped.
- Per-cycle selection, in priority order:
  1. A_VALID && A_ADDR!=0: write A.
  2. Else FIFO non-empty: pop the head. If the head is valid, write it; if squashed, REG_WRITE_EN=0 that cycle.
  3. Else REG_WRITE_EN=0.
- There is no bypass path. A B transfer into an empty FIFO is enqueued and written no earlier than 2 cycles after acceptance.
- B_READY = (count < DEPTH), from registered count only. No same-cycle pop-to-push pass-through when full.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- x0 handling:
  - A with A_ADDR=0 produces no write and squashes nothing.
  - B with B_ADDR=0 is handshaken (accepted when ready) but not enqueued.
- Squash (WAW):
  - When A_VALID && A_ADDR!=0, every valid FIFO entry with matching address has its valid bit cleared that cycle.
  - A B transfer accepted in the same cycle with the same address is enqueued already squashed, because same-cycle B is defined as older than A.
- Ordering guarantee relied on: the pipeline issues A results younger than every B result accepted at or before the same cycle.
- Data is passed through unmodified; there is no width conversion.

Optional Feature:
- Macro: WB_PENDING_MASK_EN.
- Defined: adds output PENDING_MASK [2**ADDR_WIDTH-1:0]. Bit i is 1 iff some valid (non-squashed) FIFO entry targets xi. It is combinational from FIFO state and is used by the hazard unit for stall decisions. Reset value is 0.
- Undefined: the port and its logic are absent; the hazard unit stalls on BUSY instead.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - the wb_entry_t typedef {valid, addr, data}
  - the constant REG_ZERO=0
- One sub-module, wb_fifo: circular buffer of wb_entry_t with push, pop, count, and a per-entry squash-by-address input.
- Arbitration and the output registers stay in wb_write_arbiter.

Test Plan:
- A only: A_VALID=1, A_ADDR=1, A_DATA=32'h12345678 -> next cycle REG_WRITE_EN=1, ADDR=1, DATA=32'h12345678; BUSY=0.
- B drain: B writes x3=32'hABCDEFF0 with A idle -> B_READY=1, BUSY=1 for one cycle, then write of x3 two cycles after acceptance.
- Contention and full: A valid on x2 every cycle while B pushes 4 entries -> B_READY=0 after the 4th push; entries write in FIFO order once A stops; B_READY returns to 1 after the first pop.
- Squash: B pushes x5=32'h11111111, then A writes x5=32'h22222222 while the entry is still buffered -> only 32'h22222222 is written to x5; squashed pop shows REG_WRITE_EN=0. Repeat with same-cycle B and A to x5 -> same result.
- x0 and reset: A_ADDR=0 and B_ADDR=0 with data 32'h98765432 -> no write, BUSY stays 0. Assert RESET=0 mid-drain with 3 entries -> immediate REG_WRITE_EN=0, BUSY=0, and no writes after release.
